systolic_skew_feeder: RTL

SYSTOLIC_SKEW_FEEDER -- requirements
Module: systolic_skew_feeder

---
 rtl/systolic_skew_feeder.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/systolic_skew_feeder.sv
// Systolic array edge feeder: takes one A column slice and one B row slice per
// beat and staggers lane i by i+1 enabled cycles so operands meet in step at
// each PE. Sequencing: IDLE -> CLEAR -> STREAM (K beats) -> FLUSH (2*N) -> DONE.
// Optional macro FEEDER_STALL_CNT_EN adds a saturating stall_cnt output.
module systolic_skew_feeder #(
    parameter int unsigned DW = 16,
    parameter int unsigned N  = 4,
    parameter int unsigned K  = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N*DW-1:0] a_in,
    input  logic [N*DW-1:0] b_in,
    output logic [N*DW-1:0] a_out,
    output logic [N*DW-1:0] b_out,
    output logic            pe_en,
    output logic            pe_rst,
    output logic            busy,
`ifdef FEEDER_STALL_CNT_EN
    output logic [15:0]     stall_cnt,
`endif
    output logic            done
);

    localparam int unsigned FW = $clog2(2 * N) + 1;
    localparam logic [FW-1:0] FlushLast = FW'(2 * N - 1);
    localparam logic [7:0]    BeatLast  = 8'(K - 1);

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StStream,
        StFlush,
        StDone
    } state_e;

    state_e          r_state;
    state_e          w_state_d;
    logic [7:0]      r_beat_cnt;
    logic [7:0]      w_beat_cnt_d;
    logic [FW-1:0]   r_flush_cnt;
    logic [FW-1:0]   w_flush_cnt_d;
    logic            w_clr;
    logic [N*DW-1:0] w_a_shin;
    logic [N*DW-1:0] w_b_shin;

    // State and counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= StIdle;
            r_beat_cnt  <= '0;
            r_flush_cnt <= '0;
        end else begin
            r_state     <= w_state_d;
            r_beat_cnt  <= w_beat_cnt_d;
            r_flush_cnt <= w_flush_cnt_d;
        end
    end

    // Next-state, handshake and array control decode.
    always_comb begin
        w_state_d     = r_state;
        w_beat_cnt_d  = r_beat_cnt;
        w_flush_cnt_d = r_flush_cnt;
        in_ready      = 1'b0;
        pe_en         = 1'b0;
        done          = 1'b0;
        w_clr         = 1'b0;
        w_a_shin      = '0;
        w_b_shin      = '0;
        unique case (r_state)
            StIdle: begin
                // A request only wakes the block; the beat is taken in STREAM.
                if (in_valid) w_state_d = StClear;
            end
            StClear: begin
                w_clr         = 1'b1;
                w_beat_cnt_d  = '0;
                w_flush_cnt_d = '0;
                w_state_d     = StStream;
            end
            StStream: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    pe_en    = 1'b1;
                    w_a_shin = a_in;
                    w_b_shin = b_in;
                    if (r_beat_cnt == BeatLast) begin
                        w_flush_cnt_d = '0;
                        w_state_d     = StFlush;
                    end else begin
                        w_beat_cnt_d = r_beat_cnt + 8'd1;
                    end
                end
            end
            StFlush: begin
                // Zeros are shifted in so the tail of the tile drains through.
                pe_en = 1'b1;
                if (r_flush_cnt == FlushLast) begin
                    w_state_d = StDone;
                end else begin
                    w_flush_cnt_d = r_flush_cnt + 1'b1;
                end
            end
            StDone: begin
                done      = 1'b1;
                w_state_d = StIdle;
            end
            default: w_state_d = StIdle;
        endcase
        // Reset is synchronous, so mask controls during the reset cycle itself.
        if (rst) begin
            in_ready = 1'b0;
            pe_en    = 1'b0;
            done     = 1'b0;
        end
    end

    assign busy   = !rst && (r_state != StIdle);
    assign pe_rst = rst || (r_state == StClear);

    // Per-lane skew shift registers, lane i is i+1 stages deep.
    for (genvar i = 0; i < N; i++) begin : g_lane
        logic [DW-1:0] r_a_sr [0:i];
        logic [DW-1:0] r_b_sr [0:i];

        // Shift only on enabled cycles; cleared by reset and CLEAR.
        always_ff @(posedge clk) begin
            if (rst || w_clr) begin
                for (int k = 0; k <= i; k++) begin
                    r_a_sr[k] <= '0;
                    r_b_sr[k] <= '0;
                end
            end else if (pe_en) begin
                r_a_sr[0] <= w_a_shin[i*DW +: DW];
                r_b_sr[0] <= w_b_shin[i*DW +: DW];
                for (int k = 1; k <= i; k++) begin
                    r_a_sr[k] <= r_a_sr[k-1];
                    r_b_sr[k] <= r_b_sr[k-1];
                end
            end
        end

        assign a_out[i*DW +: DW] = r_a_sr[i];
        assign b_out[i*DW +: DW] = r_b_sr[i];
    end

`ifdef FEEDER_STALL_CNT_EN
    logic [15:0] r_stall_cnt;

    // Count STREAM cycles with no beat offered, saturating.
    always_ff @(posedge clk) begin
        if (rst || w_clr) begin
            r_stall_cnt <= '0;
        end else if ((r_state == StStream) && !in_valid && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule
